// File: rtl/mux_scan_rx.sv
// mux_scan_rx: drives the select lines of an external 4:1 bit mux, lets each
// index settle for SETTLE_CYCLES idle cycles, samples the mux output and
// reassembles the 4-bit source word with a one-cycle done strobe.
module mux_scan_rx #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       din,
    output logic [1:0] select,
    output logic [3:0] dataout,
    output logic       done,
    output logic       busy
);

    // The settle counter must hold SETTLE_CYCLES and is never narrower than one bit.
    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_VAL = CW'(SETTLE_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      shadow_q, shadow_d;
    logic [3:0]      dataout_q, dataout_d;
    logic            done_q, done_d;

    // Next-state logic: settle countdown, per-index sampling and word commit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        dataout_d = dataout_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    idx_d    = 2'd0;
                    cnt_d    = SETTLE_VAL;
                    shadow_d = 3'b000;
                end
            end
            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (idx_q != 2'd3) begin
                    case (idx_q)
                        2'd0:    shadow_d[0] = din;
                        2'd1:    shadow_d[1] = din;
                        2'd2:    shadow_d[2] = din;
                        default: shadow_d    = shadow_q;
                    endcase
                    idx_d = idx_q + 2'd1;
                    cnt_d = SETTLE_VAL;
                end else begin
                    dataout_d = {din, shadow_q};
                    done_d    = 1'b1;
                    idx_d     = 2'd0;
                    if (continuous) begin
                        cnt_d    = SETTLE_VAL;
                        shadow_d = 3'b000;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and output registers; reset discards any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            shadow_q  <= 3'b000;
            dataout_q <= 4'b0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            dataout_q <= dataout_d;
            done_q    <= done_d;
        end
    end

    assign select  = idx_q;
    assign dataout = dataout_q;
    assign done    = done_q;
    assign busy    = (state_q == ST_SCAN);

endmodule
